// File: rtl/serial_adder_param_if.sv
// Handshake and operand/result bundle for serial_adder_param.
// Carries the extra sub request when SERIAL_ADDER_SUBTRACT_EN is defined.
interface serial_adder_param_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
`ifdef SERIAL_ADDER_SUBTRACT_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             ovf;

`ifdef SERIAL_ADDER_SUBTRACT_EN
   modport master (output start, A, B, Cin, sub, input busy, done, S, Cout, ovf);
   modport slave  (input start, A, B, Cin, sub, output busy, done, S, Cout, ovf);
`else
   modport master (output start, A, B, Cin, input busy, done, S, Cout, ovf);
   modport slave  (input start, A, B, Cin, output busy, done, S, Cout, ovf);
`endif
endinterface

// File: rtl/serial_adder_param.sv
// Digit-serial adder: S = A + B + Cin over WIDTH/DIGIT cycles, LSB digit first.
// Optional macro SERIAL_ADDER_SUBTRACT_EN adds a sub request (A - B).
module serial_adder_param #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_adder_param_if.slave bus
);
   localparam int unsigned N  = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DW = DIGIT + 1;

   if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_adder_param: DIGIT must be >= 1 and divide WIDTH");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_ovf;

   logic             w_load;
   logic             w_step;
   logic             w_finish;
   logic             w_cnt_last;
   logic [DW-1:0]    w_dsum;
   logic [WIDTH-1:0] w_res_next;
   logic             w_cmsb;
   logic             w_sub;
   logic [WIDTH-1:0] w_b_lat;
   logic             w_c_lat;

`ifdef SERIAL_ADDER_SUBTRACT_EN
   assign w_sub = bus.sub;
`else
   assign w_sub = 1'b0;
`endif

   // Subtraction is A + ~B + 1, so Cin is ignored when sub is set.
   assign w_b_lat = w_sub ? ~bus.B : bus.B;
   assign w_c_lat = w_sub ? 1'b1 : bus.Cin;

   assign w_cnt_last = (r_cnt == CW'(N - 1));
   assign w_dsum     = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + DW'(r_carry);
   assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
   // Carry into the operand MSB, recovered from the top bit of the final digit.
   assign w_cmsb     = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.start) w_state_next = ST_RUN;
         ST_RUN:  if (w_cnt_last) w_state_next = ST_DONE;
         ST_DONE: w_state_next = bus.start ? ST_RUN : ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Datapath controls decoded from the state.
   always_comb begin
      w_load   = 1'b0;
      w_step   = 1'b0;
      w_finish = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: w_load = bus.start;
         ST_RUN: begin
            w_step   = 1'b1;
            w_finish = w_cnt_last;
         end
         default: ;
      endcase
   end

   // Operand/result shift registers, carry, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_load) begin
            r_a     <= bus.A;
            r_b     <= w_b_lat;
            r_carry <= w_c_lat;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
         end else if (w_step) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_dsum[DIGIT];
            r_res   <= w_res_next;
            r_cnt   <= r_cnt + CW'(1);
         end
         if (w_finish) begin
            r_s    <= w_res_next;
            r_cout <= w_dsum[DIGIT];
            r_ovf  <= w_cmsb ^ w_dsum[DIGIT];
            r_busy <= 1'b0;
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.S    = r_s;
   assign bus.Cout = r_cout;
   assign bus.ovf  = r_ovf;
endmodule
